// File: rtl/program_loader_if.sv
// Byte-receive and program-memory write signals shared between the bootloader and its environment.
interface program_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  wr_addr;
   logic [15:0] wr_data;
   logic [1:0]  we;
   logic        cpu_reset;
   logic        busy;
   logic        done;
   logic        err;

   modport slave (
      input  rx_data, rx_valid,
      output wr_addr, wr_data, we, cpu_reset, busy, done, err
   );

   modport master (
      output rx_data, rx_valid,
      input  wr_addr, wr_data, we, cpu_reset, busy, done, err
   );
endinterface

// File: rtl/program_loader.sv
// Byte-stream bootloader: SYNC, N, N big-endian words, CSUM -> program-memory writes,
// holding the processor in reset until a checksum-verified load completes.
module program_loader #(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 100000,
   parameter int         TO_W           = 17
) (
   input  logic               clk,
   input  logic               reset,
   program_loader_if.slave    bus
);

   typedef enum logic [2:0] {IDLE, COUNT, HI, LO, CSUM, DONE, ERR} state_t;

   state_t            state, state_nxt;
   logic [7:0]        wr_addr;
   logic [15:0]       wr_data;
   logic [1:0]        we;
   logic              cpu_reset, busy, done, err;
   logic [7:0]        csum;
   logic [8:0]        words_left;
   logic [TO_W-1:0]   to_cnt;

   logic in_frame, timeout, sync_hit, accept;

   assign in_frame = (state == COUNT) || (state == HI) || (state == LO) || (state == CSUM);
   assign timeout  = in_frame && !bus.rx_valid && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign sync_hit = bus.rx_valid && (bus.rx_data == SYNC_BYTE) &&
                     ((state == IDLE) || (state == DONE) || (state == ERR));
   assign accept   = bus.rx_valid && !timeout;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (timeout) begin
         state_nxt = ERR;
      end else if (bus.rx_valid) begin
         case (state)
            IDLE, DONE, ERR: if (bus.rx_data == SYNC_BYTE) state_nxt = COUNT;
            COUNT:           state_nxt = HI;
            HI:              state_nxt = LO;
            LO:              state_nxt = (words_left == 9'd1) ? CSUM : HI;
            CSUM:            state_nxt = (bus.rx_data == csum) ? DONE : ERR;
            default:         state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_addr    <= '0;
         wr_data    <= '0;
         we         <= 2'b00;
         cpu_reset  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         csum       <= '0;
         words_left <= '0;
         to_cnt     <= '0;
      end else begin
         we <= 2'b00;
         // Address advances as the write pulse retires, so the pulse sees a stable address.
         if (we == 2'b11) wr_addr <= wr_addr + 8'd1;

         if (!in_frame || bus.rx_valid || timeout) to_cnt <= '0;
         else                                      to_cnt <= to_cnt + 1'b1;

         if (sync_hit) begin
            busy      <= 1'b1;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            wr_addr   <= '0;
            csum      <= '0;
         end

         if (accept) begin
            case (state)
               COUNT: words_left <= (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
               HI: begin
                  wr_data[15:8] <= bus.rx_data;
                  csum          <= csum + bus.rx_data;
               end
               LO: begin
                  wr_data[7:0] <= bus.rx_data;
                  csum         <= csum + bus.rx_data;
                  we           <= 2'b11;
                  words_left   <= words_left - 9'd1;
               end
               default: ;
            endcase
         end

         if (state_nxt == DONE && state != DONE) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            cpu_reset <= 1'b0;
         end
         if (state_nxt == ERR && state != ERR) begin
            err  <= 1'b1;
            busy <= 1'b0;
         end
      end
   end

   assign bus.wr_addr   = wr_addr;
   assign bus.wr_data   = wr_data;
   assign bus.we        = we;
   assign bus.cpu_reset = cpu_reset;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.err       = err;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream bootloader upstream of the processor top.
- Takes received bytes from a serial receiver, assembles 16-bit instruction words and drives the processor's program-memory write port (wr_addr, wr_data, we).
- Holds the processor in reset while a load is in progress. Releases it only after a checksum-verified load completes.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 100000, maximum idle clocks allowed between bytes inside a frame.
- TO_W, 17, width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- wr_addr  out  8  program-memory write address.
- wr_data  out  16  instruction word.
- we  out  2  program-memory write enable. 2'b11 = full-word write; 2'b00 otherwise.
- cpu_reset  out  1  active-high hold for the processor.
- busy  out  1  a frame is in progress.
- done  out  1  last load succeeded. Sticky.
- err  out  1  last load failed (checksum or timeout). Sticky.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low.
- Values while reset is low:
  - state=IDLE, wr_addr=0, wr_data=0, we=2'b00.
  - cpu_reset=1, busy=0, done=0, err=0.
  - checksum accumulator=0, word counter=0, timeout counter=0.
- Frame format: SYNC_BYTE, N, then N words each sent as high byte followed by low byte, then CSUM.
  - N=0 means 256 words.
  - CSUM = 8-bit sum (mod 256) of all 2N data bytes. N and SYNC_BYTE are not included.
- States: IDLE, COUNT, HI, LO, CSUM, DONE, ERR. In every state, a cycle without rx_valid holds the current state.
- IDLE:
  - rx_valid with rx_data==SYNC_BYTE → COUNT.
  - At that transition: busy=1, cpu_reset=1, done=0, err=0, wr_addr=0 (first write goes to address 0), checksum=0.
  - Any other byte is ignored.
- COUNT: on rx_valid, latch N as word count (0 is treated as 256) → HI.
- HI: on rx_valid, latch the byte into wr_data[15:8], add it to checksum → LO.
- LO: on rx_valid, latch the byte into wr_data[7:0] and add it to checksum.
  - In the next cycle, we=2'b11 for exactly one cycle with stable wr_addr/wr_data.
  - wr_addr increments by 1 in the cycle after the we pulse. It is 8 bits and wraps, so N=256 ends with the last write at address 255.
  - Then go to HI if words remain, else CSUM.
  - There is no dead cycle: a byte arriving in the same cycle as the we pulse is accepted by HI/CSUM without corrupting the write in progress (wr_data[15:8] is updated only after the pulse).
- CSUM: on rx_valid, compare the byte with the accumulator.
  - Match → DONE.
  - Mismatch → ERR.
- DONE: busy=0, done=1, cpu_reset=0. Behaves as IDLE: a SYNC_BYTE starts a new load and immediately reasserts cpu_reset.
- ERR: busy=0, err=1, cpu_reset stays 1. Behaves as IDLE for resync.
- Timeout:
  - In COUNT/HI/LO/CSUM, the counter increments every cycle without rx_valid and clears on rx_valid.
  - Reaching TIMEOUT_CYCLES → ERR.
  - In all other states the counter is held at 0.
- SYNC_BYTE value inside a frame is treated as data. There is no resync mid-frame.
- Reset mid-frame: immediate return to the reset values. Partially written memory is not cleaned; cpu_reset stays 1.
- we is never asserted outside the single cycle that follows an LO byte.

Test Plan:
- Nominal load:
  - Stimulus: A5,02,12,34,AB,CD,BE.
  - Required: we=11 pulses at addr0 data 1234 and addr1 data ABCD; then done=1, cpu_reset=0, busy=0, err=0.
- Bad checksum:
  - Stimulus: the same frame with CSUM=BF.
  - Required: both writes occur, then err=1, done=0, cpu_reset remains 1.
- Back-to-back bytes:
  - Stimulus: rx_valid asserted every cycle for the nominal frame.
  - Required: identical writes, no dropped byte, each we pulse exactly 1 cycle.
- Timeout:
  - Stimulus: A5,01,12, then silence for TIMEOUT_CYCLES (set to 50 in the bench).
  - Required: err=1 after the 50th idle cycle, no we pulse; a following valid frame A5,01,00,01,01 gives done=1.
- Noise, reload and N=256:
  - Stimulus: bytes 00,FF in IDLE, then a load with N=0 and 512 bytes.
  - Required: noise ignored; 256 writes at addresses 0..255 in order; wr_addr wraps; done=1.
  - Stimulus: while in DONE, send A5.
  - Required: cpu_reset=1 and done=0 the next cycle.
- Reset mid-frame:
  - Stimulus: drive reset low after the HI byte of word 1.
  - Required: all outputs return to reset values asynchronously; no we pulse after reset is released until a new frame completes an LO byte.
